// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the shared-ALU sequencer and its ALU.
// Opcode values match the alu_ov encoding.
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // Operation captured at grant time; the ALU only ever sees this.
  typedef struct packed {
    logic        id;
    logic        ovchk;
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [31:0] r;
    logic        z;
    logic        ov;
    logic        wen;
  } rsp_t;

  function automatic logic is_addsub(input logic [3:0] aluc);
    return (aluc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_ov.sv
// 32-bit MIPS-style ALU with signed add/sub overflow flag.
// Purely combinational; no handshake.
// Backpressure: none.
module alu_ov (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        z,
  output logic        v
);

  logic [31:0] bx;
  logic [31:0] sum;

  always_comb begin
    bx  = aluc[2] ? ~b : b;
    sum = a + bx + {31'd0, aluc[2]};
    r   = 32'd0;
    v   = 1'b0;
    case (aluc[1:0])
      2'b00: begin
        r = sum;
        v = (a[31] == bx[31]) && (sum[31] != a[31]);
      end
      2'b01: r = aluc[2] ? (a | b) : (a & b);
      2'b10: r = aluc[2] ? {b[15:0], 16'h0000} : (a ^ b);
      default: begin
        if (!aluc[2])
          r = b << a[4:0];
        else if (aluc[3])
          r = $signed(b) >>> a[4:0];
        else
          r = b >> a[4:0];
      end
    endcase
    z = (r == 32'd0);
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin shares one alu_ov between two requesters, with sticky overflow flag.
// Latency: accept at T, rsp_valid at T+2; at most one op in flight (3 cycles min).
// Backpressure: response held until rsp_ready; no request accepted until then.
module alu_share_ctrl #(
  parameter logic TRAP_ON_OV = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_aluc,
  input  logic        req0_ovchk,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_aluc,
  input  logic        req1_ovchk,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_r,
  output logic        rsp_z,
  output logic        rsp_ov,
  output logic        rsp_wen,
  output logic        ov_pending,
  output logic        ov_id,
  input  logic        ov_clr
);

  import alu_share_ctrl_pkg::*;

  state_t      state_q, state_d;
  logic        last_grant_q;
  op_t         op_q;
  rsp_t        rsp_q;
  logic        ov_pending_q, ov_id_q;
  logic        any_vld, gnt, accept;
  logic [31:0] alu_r;
  logic        alu_z, alu_v, ov_now;

  // Tie goes to whoever did not win last; a lone valid always wins.
  always_comb begin
    any_vld = req0_valid | req1_valid;
    gnt     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          accept     = 1'b1;
          req0_ready = ~gnt;
          req1_ready = gnt;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  alu_ov u_alu (
    .a    (op_q.a),
    .b    (op_q.b),
    .aluc (op_q.aluc),
    .r    (alu_r),
    .z    (alu_z),
    .v    (alu_v)
  );

  assign ov_now = alu_v & op_q.ovchk & is_addsub(op_q.aluc);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      rsp_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= gnt;
        op_q.id      <= gnt;
        op_q.ovchk   <= gnt ? req1_ovchk : req0_ovchk;
        op_q.aluc    <= gnt ? req1_aluc  : req0_aluc;
        op_q.a       <= gnt ? req1_a     : req0_a;
        op_q.b       <= gnt ? req1_b     : req0_b;
      end
      if (state_q == EXEC) begin
        rsp_q.id  <= op_q.id;
        rsp_q.r   <= alu_r;
        rsp_q.z   <= alu_z;
        rsp_q.ov  <= ov_now;
        rsp_q.wen <= ~(TRAP_ON_OV & ov_now);
      end
    end
  end

  // A new overflow beats a same-cycle clear; otherwise the first cause is kept.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ov_pending_q <= 1'b0;
      ov_id_q      <= 1'b0;
    end else if ((state_q == EXEC) && ov_now) begin
      ov_pending_q <= 1'b1;
      if (!ov_pending_q || ov_clr)
        ov_id_q <= op_q.id;
    end else if (ov_clr) begin
      ov_pending_q <= 1'b0;
    end
  end

  assign rsp_id     = rsp_q.id;
  assign rsp_r      = rsp_q.r;
  assign rsp_z      = rsp_q.z;
  assign rsp_ov     = rsp_q.ov;
  assign rsp_wen    = rsp_q.wen;
  assign ov_pending = ov_pending_q;
  assign ov_id      = ov_id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a cycle model and response scoreboard.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_aluc, req1_aluc;
  logic        req0_ovchk, req1_ovchk;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_ov, rsp_wen;
  logic [31:0] rsp_r;
  logic        ov_pending, ov_id, ov_clr;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_aluc(req0_aluc), .req0_ovchk(req0_ovchk),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_aluc(req1_aluc), .req1_ovchk(req1_ovchk),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_z(rsp_z), .rsp_ov(rsp_ov), .rsp_wen(rsp_wen),
    .ov_pending(ov_pending), .ov_id(ov_id), .ov_clr(ov_clr)
  );

  typedef struct {
    logic        id;
    logic [31:0] r;
    logic        z;
    logic        ov;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_st;
  logic m_last, m_ovp, m_ovid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t alu_model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] c, input logic ck);
    exp_t        e;
    logic [31:0] r;
    logic        v;
    r = 32'd0;
    v = 1'b0;
    case (c)
      ALUC_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALUC_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALUC_AND: r = a & b;
      ALUC_OR:  r = a | b;
      ALUC_XOR: r = a ^ b;
      ALUC_LUI: r = {b[15:0], 16'h0000};
      ALUC_SLL: r = b << a[4:0];
      ALUC_SRL: r = b >> a[4:0];
      ALUC_SRA: r = $unsigned($signed(b) >>> a[4:0]);
      default:  r = 32'd0;
    endcase
    e.id  = id;
    e.r   = r;
    e.z   = (r == 32'd0);
    e.ov  = v & ck;
    e.wen = ~e.ov;
    return e;
  endfunction

  // Check the current cycle against the model, then advance the model across the next edge.
  task automatic tick();
    exp_t e;
    logic g, any, set;
    #1;
    any = req0_valid | req1_valid;
    g   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    chk("req0_ready", req0_ready, (m_st == 0) && any && !g);
    chk("req1_ready", req1_ready, (m_st == 0) && any && g);
    chk("rsp_valid", rsp_valid, m_st == 2);
    chk("ov_pending", ov_pending, m_ovp);
    chk("ov_id", ov_id, m_ovid);
    if (m_st == 2) begin
      chk("sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb[0];
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_r", rsp_r, e.r);
        chk("rsp_z", rsp_z, e.z);
        chk("rsp_ov", rsp_ov, e.ov);
        chk("rsp_wen", rsp_wen, e.wen);
      end
    end
    if (!clrn) begin
      m_st = 0; m_last = 1'b1; m_ovp = 1'b0; m_ovid = 1'b0;
      sb.delete();
    end else begin
      set = (m_st == 1) && (sb.size() > 0) && sb[$].ov;
      if (set) begin
        if (!m_ovp || ov_clr) m_ovid = sb[$].id;
        m_ovp = 1'b1;
      end else if (ov_clr) begin
        m_ovp = 1'b0;
      end
      case (m_st)
        0: if (any) begin
          e = g ? alu_model(1'b1, req1_a, req1_b, req1_aluc, req1_ovchk)
                : alu_model(1'b0, req0_a, req0_b, req0_aluc, req0_ovchk);
          sb.push_back(e);
          m_last = g;
          m_st   = 1;
        end
        1: m_st = 2;
        default: if (rsp_ready) begin
          void'(sb.pop_front());
          m_st = 0;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int which, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic ck);
    if (which == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = c; req0_ovchk = ck;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = c; req1_ovchk = ck;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((m_st != 0) && (n < 20)) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 20, 1);
  endtask

  task automatic one_op(input int which, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic ck);
    set_req(which, a, b, c, ck);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0] ops [9];
    ops = '{ALUC_ADD, ALUC_SUB, ALUC_AND, ALUC_OR, ALUC_XOR, ALUC_LUI, ALUC_SLL, ALUC_SRL, ALUC_SRA};
    clrn = 1'b0; rsp_ready = 1'b1; ov_clr = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluc = '0; req0_ovchk = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluc = '0; req1_ovchk = 1'b0;
    m_st = 0; m_last = 1'b1; m_ovp = 1'b0; m_ovid = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_rsp_r", rsp_r, 32'd0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_rsp_ov", rsp_ov, 0);
    chk("rst_rsp_wen", rsp_wen, 0);
    chk("rst_rsp_id", rsp_id, 0);
    clrn = 1'b1;

    // Signed overflow, trapped and untrapped
    one_op(0, 32'h7FFF_FFFF, 32'h1, ALUC_ADD, 1'b1);
    chk("ovf_r", rsp_r, 32'h8000_0000);
    chk("ovf_ov", rsp_ov, 1);
    chk("ovf_wen", rsp_wen, 0);
    chk("ovf_pending", ov_pending, 1);
    chk("ovf_id", ov_id, 0);
    one_op(0, 32'h7FFF_FFFF, 32'h1, ALUC_ADD, 1'b0);
    chk("addu_ov", rsp_ov, 0);
    chk("addu_wen", rsp_wen, 1);

    // LUI ignores ovchk
    one_op(1, 32'h0, 32'h0000_ABCD, ALUC_LUI, 1'b1);
    chk("lui_r", rsp_r, 32'hABCD_0000);
    chk("lui_ov", rsp_ov, 0);
    chk("lui_id", rsp_id, 1);
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    chk("clr_pending", ov_pending, 0);

    // Both requesters held valid: grants alternate starting with req0
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      req0_a = $urandom; req0_b = $urandom; req0_aluc = ops[$urandom_range(0, 8)];
      req0_ovchk = 1'($urandom_range(0, 1));
      req1_a = $urandom; req1_b = $urandom; req1_aluc = ops[$urandom_range(0, 8)];
      req1_ovchk = 1'($urandom_range(0, 1));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Backpressure: response held, other requester not accepted
    rsp_ready = 1'b0;
    set_req(0, 32'h1234_5678, 32'h1234_5678, ALUC_SUB, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    tick();
    repeat (5) tick();
    chk("bp_valid", rsp_valid, 1);
    chk("bp_r", rsp_r, 32'd0);
    chk("bp_z", rsp_z, 1);
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    drain();

    one_op(0, 32'd4, 32'h8000_0000, ALUC_SRA, 1'b1);
    chk("sra_r", rsp_r, 32'hF800_0000);
    chk("sra_ov", rsp_ov, 0);

    // Overflow cause priority
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    one_op(1, 32'h8000_0000, 32'h1, ALUC_SUB, 1'b1);
    chk("first_ov_id", ov_id, 1);
    one_op(0, 32'h7FFF_FFFF, 32'h1, ALUC_ADD, 1'b1);
    chk("kept_ov_id", ov_id, 1);
    chk("kept_pending", ov_pending, 1);
    set_req(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, ALUC_ADD, 1'b1);
    tick();
    req0_valid = 1'b0;
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    chk("setclr_pending", ov_pending, 1);
    chk("setclr_id", ov_id, 0);
    drain();

    // Reset during EXEC, then during RESP
    set_req(0, 32'd5, 32'd6, ALUC_ADD, 1'b1);
    tick();
    req0_valid = 1'b0;
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    chk("rst_exec_valid", rsp_valid, 0);
    chk("rst_exec_pending", ov_pending, 0);
    rsp_ready = 1'b0;
    set_req(1, 32'd1, 32'd2, ALUC_ADD, 1'b0);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("pre_rst_valid", rsp_valid, 1);
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    rsp_ready = 1'b1;
    chk("rst_resp_valid", rsp_valid, 0);
    set_req(0, 32'd10, 32'd3, ALUC_SUB, 1'b1);
    set_req(1, 32'd20, 32'd3, ALUC_SUB, 1'b1);
    #1;
    chk("tie_req0_ready", req0_ready, 1);
    chk("tie_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    chk("tie_rsp_id", rsp_id, 0);
    chk("tie_rsp_r", rsp_r, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences and shares one alu_ov datapath between two requesters, e.g. pipeline EX stage (req0) and exception/CP0 address-calc path (req1).
- Round-robin arbitration, registered operands and result, valid/ready handshakes on both sides.
- Reports arithmetic overflow per response and holds a sticky overflow-exception flag for the interrupt/exception controller.

Parameters:
- TRAP_ON_OV, 1, when 1 an overflow-checked op that overflows deasserts rsp_wen (result must not be written back); when 0 rsp_wen is always 1.

Ports:
- clk  in  1  clock, all state on rising edge
- clrn  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  32  operand a (shift amount in a[4:0])
- req0_b  in  32  operand b
- req0_aluc  in  4  ALU op code, same encoding as alu_ov
- req0_ovchk  in  1  1 = signed op (add/sub), overflow traps; 0 = unsigned (addu/subu)
- req1_valid, req1_ready, req1_a, req1_b, req1_aluc, req1_ovchk  same as requester 0
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_r  out  32  ALU result
- rsp_z  out  1  zero flag
- rsp_ov  out  1  overflow flag, = alu v & captured ovchk
- rsp_wen  out  1  writeback permitted
- ov_pending  out  1  sticky overflow exception
- ov_id  out  1  requester that caused ov_pending
- ov_clr  in  1  clears ov_pending

Behaviour:
- Reset (clrn=0 at posedge): state=IDLE, last_grant=1 (req0 wins first tie). req*_ready=0, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_z=0, rsp_ov=0, rsp_wen=0, ov_pending=0, ov_id=0. Reset mid-operation drops the in-flight op silently.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational and asserted only in IDLE for the granted requester.
  - Grant rule: only one valid -> grant it; both valid -> grant the one != last_grant.
  - On grant: capture a, b, aluc, ovchk and id into operand regs; update last_grant; go to EXEC.
  - No valid -> stay in IDLE.
- EXEC: alu_ov is driven only from the operand regs.
  - Register r -> rsp_r and z -> rsp_z.
  - rsp_ov = v & ovchk.
  - rsp_wen = ~(TRAP_ON_OV & rsp_ov).
  - Go to RESP.
- RESP: rsp_valid=1.
  - rsp_id/r/z/ov/wen hold stable until rsp_valid & rsp_ready.
  - On handshake: go to IDLE, rsp_valid=0 next cycle.
  - No new request is accepted in RESP.
- Latency: accept at cycle T, rsp_valid at T+2. Minimum 3 cycles per op.
- ALU result depends only on operand regs, never on live req inputs. Requester inputs may change after the ready cycle.
- ov_pending:
  - Set in the EXEC cycle when rsp_ov computes to 1; ov_id=captured id.
  - Cleared by ov_clr.
  - Set and clear in the same cycle -> set wins, ov_id updated.
  - Second overflow while pending: ov_pending stays 1 and ov_id is NOT overwritten (first cause kept).
- Overflow is meaningful only for ADD/SUB codes (aluc[1:0]=00). Logic, LUI and shift ops always give rsp_ov=0 regardless of ovchk.
- A requester withdrawing valid while not granted is legal. Grant evaluation uses the current cycle's valids only.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2
  - ALU opcode constants ALUC_ADD=4'b0000, ALUC_SUB=4'b0100, ALUC_AND=4'b0001, ALUC_OR=4'b0101, ALUC_XOR=4'b0010, ALUC_LUI=4'b0110, ALUC_SLL=4'b0011, ALUC_SRL=4'b0111, ALUC_SRA=4'b1111
- Sub-module: instantiate the existing alu_ov unchanged. The round-robin grant logic may be a small rr_arb2 sub-module; everything else stays in alu_share_ctrl.

Test Plan:
- Signed overflow: req0 a=0x7FFFFFFF b=0x00000001 aluc=0000 ovchk=1 -> at T+2: rsp_r=0x80000000, rsp_ov=1, rsp_wen=0, ov_pending=1, ov_id=0. Same op with ovchk=0 -> rsp_ov=0, rsp_wen=1.
- Arbitration fairness: req0 and req1 both held valid continuously -> grants alternate 0,1,0,1 starting with req0. rsp_id follows the same sequence. Each op takes 3 cycles when rsp_ready=1.
- Backpressure: SUB a=b=0x12345678, rsp_ready=0 for 5 cycles -> rsp_valid=1 with rsp_r=0, rsp_z=1 held stable. req*_ready stays 0 throughout. Completes when rsp_ready=1.
- Shift/logic paths:
  - SRA b=0x80000000 a=4 aluc=1111 -> rsp_r=0xF8000000, rsp_ov=0.
  - LUI b=0x0000ABCD aluc=0110 ovchk=1 -> rsp_r=0xABCD0000, rsp_ov=0.
- ov_pending priority: overflow from req1 then overflow from req0 -> ov_id stays 1. Assert ov_clr in the same cycle as a new overflow EXEC -> ov_pending stays 1.
- Reset mid-op: clrn=0 during EXEC or RESP -> next cycle state IDLE, rsp_valid=0, ov_pending=0. Tie resolution after reset grants req0.
